router_pkt_tx: RTL

Packet transmitter feeding the router's input port. It accepts a packet command (destination address, payload length) and a byte stream of payload. It buffers the whole payload, then serializes header, payload and parity onto the router's `pkt_valid`/`data_out` lines, honouring the router's `busy` backpressure. It sits upstream of the router as the source side of the router packet protocol: header `{len[5:0], addr[1:0]}`, then `len` payload bytes, then one XOR parity byte.

---
 rtl/router_pkg.sv | 24 ++
 rtl/pkt_tx_buf.sv | 26 ++
 rtl/router_pkt_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet transmitter.
// Header layout on the wire is {len[5:0], addr[1:0]}.
package router_pkg;

    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR,
        ST_PLD,
        ST_PAR,
        ST_GAP
    } tx_state_e;

    function automatic logic [DATA_W-1:0] pack_hdr(input logic [LEN_W-1:0] len,
                                                   input logic [1:0]       addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/pkt_tx_buf.sv
// Payload store for one packet: synchronous write, combinational read.
// Pointers are owned by the parent.
module pkt_tx_buf
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [LEN_W-1:0]  wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [LEN_W-1:0]  rd,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << LEN_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr] <= wdata;
        end
    end

    assign rdata = mem[rd];

endmodule

// File: rtl/router_pkt_tx.sv
// Source side of the router packet protocol: buffers a whole payload, then
// sends header, payload and XOR parity under busy backpressure.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_bad_par,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              tx_done,
    output logic              cmd_err
);

    tx_state_e         state;
    logic [LEN_W-1:0]  wr_ptr;
    logic [LEN_W-1:0]  rd_ptr;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        addr_q;
    logic              bad_par_q;
    logic [DATA_W-1:0] parity;
    logic [DATA_W-1:0] buf_rdata;
    logic              cmd_fire;
    logic              pl_fire;
    logic              cmd_bad;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign pl_fire  = pl_valid & pl_ready;
    assign cmd_bad  = (cmd_addr == ADDR_INVALID) || (cmd_len == '0) ||
                      (int'(cmd_len) > MAX_LEN);

    pkt_tx_buf u_buf (
        .clk   (clk),
        .we    (pl_fire),
        .wr    (wr_ptr),
        .wdata (pl_data),
        .rd    (rd_ptr),
        .rdata (buf_rdata)
    );

    // Packet fields and running parity are plain data; control resets them
    // implicitly by only consuming them after a fresh command is accepted.
    always_ff @(posedge clk) begin
        if (cmd_fire && !cmd_bad) begin
            len_q     <= cmd_len;
            addr_q    <= cmd_addr;
            bad_par_q <= cmd_bad_par;
            parity    <= pack_hdr(cmd_len, cmd_addr);
        end else if (pl_fire) begin
            parity    <= parity ^ pl_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            pl_ready  <= 1'b0;
            pkt_valid <= 1'b0;
            data_out  <= '0;
            tx_done   <= 1'b0;
            cmd_err   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            tx_done <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        if (cmd_bad) begin
                            cmd_err <= 1'b1;
                        end else begin
                            state     <= ST_LOAD;
                            cmd_ready <= 1'b0;
                            pl_ready  <= 1'b1;
                            wr_ptr    <= '0;
                            rd_ptr    <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (pl_fire) begin
                        wr_ptr <= wr_ptr + LEN_W'(1);
                        if (wr_ptr == len_q - LEN_W'(1)) begin
                            state     <= ST_HDR;
                            pl_ready  <= 1'b0;
                            pkt_valid <= 1'b1;
                            data_out  <= pack_hdr(len_q, addr_q);
                        end
                    end
                end
                // rd_ptr runs one ahead of the byte on the wire so the buffer
                // read feeds the data_out register directly.
                ST_HDR: begin
                    if (!busy) begin
                        state    <= ST_PLD;
                        data_out <= buf_rdata;
                        rd_ptr   <= rd_ptr + LEN_W'(1);
                    end
                end
                ST_PLD: begin
                    if (!busy) begin
                        if (rd_ptr == len_q) begin
                            state     <= ST_PAR;
                            pkt_valid <= 1'b0;
                            data_out  <= parity ^ {{(DATA_W-1){1'b0}}, bad_par_q};
                        end else begin
                            data_out <= buf_rdata;
                            rd_ptr   <= rd_ptr + LEN_W'(1);
                        end
                    end
                end
                ST_PAR: begin
                    if (!busy) begin
                        state    <= ST_GAP;
                        data_out <= '0;
                        tx_done  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
